// File: rtl/stress_pkg.sv
// Shared types for the stress pattern generator: channel state encoding and
// the packed per-channel configuration record.
package stress_pkg;

    localparam int LEN_W_DEF = 6;
    localparam int NUM_W_DEF = 4;
    localparam int PER_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

    typedef struct packed {
        logic [LEN_W_DEF-1:0] seg_len;
        logic [LEN_W_DEF-1:0] seg_on;
        logic [NUM_W_DEF-1:0] seg_num;
        logic [PER_W_DEF-1:0] periods;
    } stress_cfg_t;

endpackage

// File: rtl/stress_chan.sv
// One stress channel: staged and active config, IDLE/RUN/DONE FSM, the
// q/s/p position counters and the registered-only stress output.
module stress_chan
    import stress_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  stress_cfg_t cfg,
    input  logic        start,
    input  logic        stop,
    output chan_state_e state,
    output logic        stress
);

    // Staged copy is written by the config port; the active copy is taken at
    // RUN entry, so a config landing on the same edge as a start waits.
    logic                 loaded;
    logic [LEN_W_DEF-1:0] st_on, st_g_last;
    logic [NUM_W_DEF-1:0] st_s_last;
    logic [PER_W_DEF-1:0] st_n_last;
    logic                 st_cont;

    logic [LEN_W_DEF-1:0] on, g_last;
    logic [NUM_W_DEF-1:0] s_last;
    logic [PER_W_DEF-1:0] n_last;
    logic                 cont;

    logic [LEN_W_DEF-1:0] q;
    logic [NUM_W_DEF-1:0] s;
    logic [PER_W_DEF-1:0] p;

    chan_state_e state_next;
    logic        q_wrap, s_wrap, p_end;

    assign q_wrap = (q == g_last);
    assign s_wrap = (s == s_last);
    assign p_end  = !cont && (p == n_last);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start && !stop && loaded) state_next = ST_RUN;
            ST_RUN: begin
                if (stop)                          state_next = ST_IDLE;
                else if (q_wrap && s_wrap && p_end) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (stop)       state_next = ST_IDLE;
                else if (start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            loaded    <= 1'b0;
            st_on     <= '0;
            st_g_last <= '0;
            st_s_last <= '0;
            st_n_last <= '0;
            st_cont   <= 1'b0;
            on        <= '0;
            g_last    <= '0;
            s_last    <= '0;
            n_last    <= '0;
            cont      <= 1'b0;
            q         <= '0;
            s         <= '0;
            p         <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                loaded    <= 1'b1;
                st_on     <= cfg.seg_on;
                st_g_last <= cfg.seg_len - 1'b1;
                st_s_last <= cfg.seg_num - 1'b1;
                st_n_last <= cfg.periods - 1'b1;
                st_cont   <= (cfg.periods == '0);
            end
            if (state != ST_RUN && state_next == ST_RUN) begin
                q      <= '0;
                s      <= '0;
                p      <= '0;
                on     <= st_on;
                g_last <= st_g_last;
                s_last <= st_s_last;
                n_last <= st_n_last;
                cont   <= st_cont;
            end else if (state == ST_RUN) begin
                q <= q_wrap ? '0 : q + 1'b1;
                if (q_wrap) s <= s_wrap ? '0 : s + 1'b1;
                if (q_wrap && s_wrap && !cont) p <= p + 1'b1;
            end
        end
    end

    assign stress = (state == ST_RUN) && (q < on);

endmodule

// File: rtl/stress_pattern_gen.sv
// Multi-channel stress waveform generator: shared config port with
// legality check and error pulse, fanned out to NCH independent channels.
module stress_pattern_gen
    import stress_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int LEN_W = LEN_W_DEF,
    parameter int NUM_W = NUM_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [LEN_W-1:0]       cfg_seg_len,
    input  logic [LEN_W-1:0]       cfg_seg_on,
    input  logic [NUM_W-1:0]       cfg_seg_num,
    input  logic [PER_W-1:0]       cfg_periods,
    output logic                   cfg_err,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         stress_o
);

    localparam int CH_W = $clog2(NCH);

    // Handshake: a config word transfers on any cycle where cfg_valid and
    // cfg_ready are both high; cfg_ready only drops while the target runs.
    stress_cfg_t cfg_in;
    logic        xfer, legal;
    chan_state_e chan_state [NCH];

    assign cfg_in    = '{seg_len: cfg_seg_len, seg_on: cfg_seg_on,
                         seg_num: cfg_seg_num, periods: cfg_periods};
    assign cfg_ready = !busy[cfg_ch];
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_seg_len != '0) && (cfg_seg_num != '0) &&
                       (cfg_seg_on <= cfg_seg_len);

    always_ff @(posedge clk) begin
        if (!rstn) cfg_err <= 1'b0;
        else       cfg_err <= xfer && !legal;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        stress_chan u_chan (
            .clk    (clk),
            .rstn   (rstn),
            .load   (xfer && legal && (cfg_ch == CH_W'(i))),
            .cfg    (cfg_in),
            .start  (start[i]),
            .stop   (stop[i]),
            .state  (chan_state[i]),
            .stress (stress_o[i])
        );
        assign busy[i] = (chan_state[i] == ST_RUN);
        assign done[i] = (chan_state[i] == ST_DONE);
    end

endmodule

// File: tb/tb_stress_pattern_gen.sv
// Bench for stress_pattern_gen: cycle model of each channel as "cycles since
// start" plus directed scenarios with hand-computed expectations.
module tb_stress_pattern_gen;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [5:0]     cfg_seg_len = '0;
    logic [5:0]     cfg_seg_on = '0;
    logic [3:0]     cfg_seg_num = '0;
    logic [15:0]    cfg_periods = '0;
    logic           cfg_err;
    logic [NCH-1:0] start = '0;
    logic [NCH-1:0] stop = '0;
    logic [NCH-1:0] busy, done, stress_o;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    stress_pattern_gen #(.NCH(NCH)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_seg_len(cfg_seg_len), .cfg_seg_on(cfg_seg_on),
        .cfg_seg_num(cfg_seg_num), .cfg_periods(cfg_periods), .cfg_err(cfg_err),
        .start(start), .stop(stop), .busy(busy), .done(done), .stress_o(stress_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: 0=idle 1=running 2=finished; a running channel is described by
    // the number of cycles since it started and the config it started with.
    int     m_st [NCH];
    bit     m_loaded [NCH];
    int     m_g [NCH], m_o [NCH], m_s [NCH], m_n [NCH];
    int     a_g [NCH], a_o [NCH], a_s [NCH], a_n [NCH];
    longint m_t [NCH];
    bit     m_err;

    always @(posedge clk) begin
        bit xfer, legal;
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                m_st[i] = 0; m_loaded[i] = 0; m_t[i] = 0;
            end
            m_err = 0;
        end else begin
            xfer  = cfg_valid && (m_st[cfg_ch] != 1);
            legal = (cfg_seg_len != 0) && (cfg_seg_num != 0) && (cfg_seg_on <= cfg_seg_len);
            for (int i = 0; i < NCH; i++) begin
                if (m_st[i] == 1) begin
                    if (stop[i]) m_st[i] = 0;
                    else begin
                        m_t[i]++;
                        if (a_n[i] != 0 && m_t[i] == longint'(a_g[i] * a_s[i] * a_n[i])) m_st[i] = 2;
                    end
                end else if (!stop[i] && start[i] && (m_st[i] == 2 || m_loaded[i])) begin
                    m_st[i] = 1; m_t[i] = 0;
                    a_g[i] = m_g[i]; a_o[i] = m_o[i]; a_s[i] = m_s[i]; a_n[i] = m_n[i];
                end else if (stop[i]) m_st[i] = 0;
            end
            if (xfer && legal) begin
                m_g[cfg_ch] = cfg_seg_len; m_o[cfg_ch] = cfg_seg_on;
                m_s[cfg_ch] = cfg_seg_num; m_n[cfg_ch] = cfg_periods;
                m_loaded[cfg_ch] = 1;
            end
            m_err = xfer && !legal;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("model stress_o[%0d]", i), stress_o[i],
                      (m_st[i] == 1) && ((m_t[i] % a_g[i]) < a_o[i]));
                check($sformatf("model busy[%0d]", i), busy[i], m_st[i] == 1);
                check($sformatf("model done[%0d]", i), done[i], m_st[i] == 2);
            end
            check("model cfg_err", cfg_err, m_err);
            check("model cfg_ready", cfg_ready, m_st[cfg_ch] != 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int g, input int o, input int s, input int n);
        cfg_valid = 1'b1; cfg_ch = 2'(ch);
        cfg_seg_len = 6'(g); cfg_seg_on = 6'(o); cfg_seg_num = 4'(s); cfg_periods = 16'(n);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
        start = st; stop = sp;
        step();
        start = '0; stop = '0;
    endtask

    initial begin
        logic [15:0] pat0;
        logic [23:0] pat1;

        step(); step();
        rstn = 1'b1;
        checking = 1'b1;
        check("reset stress_o", stress_o, 4'h0);
        check("reset busy", busy, 4'h0);
        check("reset done", done, 4'h0);
        check("reset cfg_err", cfg_err, 1'b0);

        // SP 1/8 continuous on ch0
        cfg(0, 8, 1, 1, 0);
        pulse(4'b0001, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            pat0[k] = stress_o[0];
            step();
        end
        check("ch0 pattern", pat0, 16'h0101);
        check("ch0 busy", busy[0], 1'b1);
        check("ch0 done", done[0], 1'b0);

        // 1,1,1,0 x 6 on ch1 then DONE
        cfg(1, 4, 3, 2, 3);
        pulse(4'b0010, 4'b0000);
        for (int k = 0; k < 24; k++) begin
            pat1[k] = stress_o[1];
            step();
        end
        check("ch1 pattern", pat1, 24'h777777);
        check("ch1 done after N", done[1], 1'b1);
        check("ch1 busy after N", busy[1], 1'b0);
        check("ch1 stress after N", stress_o[1], 1'b0);

        // restart from DONE; config to running channel is refused
        pulse(4'b0010, 4'b0000);
        cfg_valid = 1'b1; cfg_ch = 2'd1;
        cfg_seg_len = 6'd2; cfg_seg_on = 6'd0; cfg_seg_num = 4'd1; cfg_periods = 16'd0;
        #1;
        check("cfg_ready busy ch", cfg_ready, 1'b0);
        step();
        cfg_valid = 1'b0;
        check("no cfg_err on refused", cfg_err, 1'b0);
        check("ch1 stress t=1", stress_o[1], 1'b1);
        step(); step();
        check("ch1 stress t=3", stress_o[1], 1'b0);
        pulse(4'b0000, 4'b0010);
        check("ch1 stopped", busy[1], 1'b0);

        // illegal O>G on ch2
        cfg(2, 5, 6, 1, 1);
        check("cfg_err pulse", cfg_err, 1'b1);
        step();
        check("cfg_err cleared", cfg_err, 1'b0);
        pulse(4'b0100, 4'b0000);
        check("ch2 unloaded start", busy[2], 1'b0);

        // stop wins over start; start on unloaded ch3
        pulse(4'b0001, 4'b0001);
        check("ch0 stop wins busy", busy[0], 1'b0);
        check("ch0 stop wins stress", stress_o[0], 1'b0);
        pulse(4'b1000, 4'b0000);
        check("ch3 unloaded start", busy[3], 1'b0);

        // reset mid-run
        cfg(0, 3, 2, 1, 0);
        cfg(3, 4, 1, 2, 5);
        pulse(4'b1001, 4'b0000);
        repeat (5) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("midreset stress_o", stress_o, 4'h0);
        check("midreset busy", busy, 4'h0);
        check("midreset done", done, 4'h0);
        pulse(4'b1111, 4'b0000);
        check("start after reset ignored", busy, 4'h0);

        // SP 0 and SP 1
        cfg(0, 4, 0, 1, 0);
        cfg(1, 4, 4, 1, 0);
        pulse(4'b0011, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            check("sp0/sp1 stress", stress_o[1:0], 2'b10);
            check("sp0/sp1 busy", busy[1:0], 2'b11);
            step();
        end

        // config and start together: old pattern (G2 O1 N1) runs
        cfg(2, 2, 1, 1, 1);
        cfg_valid = 1'b1; cfg_ch = 2'd2;
        cfg_seg_len = 6'd4; cfg_seg_on = 6'd4; cfg_seg_num = 4'd1; cfg_periods = 16'd0;
        start = 4'b0100;
        step();
        cfg_valid = 1'b0; start = '0;
        check("ch2 old t=0", stress_o[2], 1'b1);
        step();
        check("ch2 old t=1", stress_o[2], 1'b0);
        check("ch2 old busy", busy[2], 1'b1);
        step();
        check("ch2 old done", done[2], 1'b1);
        pulse(4'b0100, 4'b0000);
        check("ch2 new t=0", stress_o[2], 1'b1);
        step(); step();
        check("ch2 new t=2", stress_o[2], 1'b1);
        pulse(4'b0000, 4'b1111);
        check("all stopped", busy, 4'h0);
        step();

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
